// File: rtl/move_piece_fsm.sv
// move_piece_fsm: applies one left/right/rotate request to the falling piece on a
// 4x8 board (cell = row*4 + col, row 0 at the top). Erase, check, then commit the
// moved or the unchanged piece, and pulse done.
// Optional build macro: WALL_KICK_EN (a blocked rotate retries one column left).
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 request strobe, sampled in IDLE
//   curr_board_state      occupancy including the current piece
//   curr_piece_type/location/rotation   current piece
//   left, right, rotate   move request (exactly one must be set to take effect)
//   new_location/new_rotation/new_board_state   committed result, held between moves
//   done                  one-cycle completion pulse
module move_piece_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] curr_board_state,
  input  logic [1:0]  curr_piece_type,
  input  logic [4:0]  curr_piece_location,
  input  logic [1:0]  curr_piece_rotation,
  input  logic        left,
  input  logic        right,
  input  logic        rotate,
  output logic [4:0]  new_location,
  output logic [1:0]  new_rotation,
  output logic [31:0] new_board_state,
  output logic        done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ERASE  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef WALL_KICK_EN
  localparam logic [2:0] S_KICK   = 3'd5;
`endif

  // Returns {in_bounds, mask}; out-of-range cells are flagged and left out of the mask.
  function automatic logic [32:0] place_piece(input logic [1:0] ptype, input logic [1:0] prot,
                                              input logic [2:0] row, input logic [2:0] col);
    logic [1:0]  dr [3];
    logic [1:0]  dc [3];
    int          n;
    logic [3:0]  rr;
    logic [3:0]  cc;
    logic        ok;
    logic [31:0] m;
    dr = '{default: 2'd0};
    dc = '{default: 2'd0};
    n  = 1;
    ok = 1'b1;
    m  = '0;
    case (ptype)
      2'b00: n = 1;
      2'b01: begin
        n = 2;
        if (prot[0]) dr[1] = 2'd1;
        else         dc[1] = 2'd1;
      end
      2'b10: begin
        n = 3;
        if (prot[0]) begin dr[1] = 2'd1; dr[2] = 2'd2; end
        else         begin dc[1] = 2'd1; dc[2] = 2'd2; end
      end
      default: begin
        n = 3;
        case (prot)
          2'd0:    begin dc[1] = 2'd1; dr[2] = 2'd1; end
          2'd1:    begin dc[1] = 2'd1; dr[2] = 2'd1; dc[2] = 2'd1; end
          // rot 2 does not occupy the anchor cell itself
          2'd2:    begin dc[0] = 2'd1; dr[1] = 2'd1; dr[2] = 2'd1; dc[2] = 2'd1; end
          default: begin dr[1] = 2'd1; dr[2] = 2'd1; dc[2] = 2'd1; end
        endcase
      end
    endcase
    for (int k = 0; k < 3; k++) begin
      if (k < n) begin
        rr = 4'(row) + 4'(dr[k]);
        cc = 4'(col) + 4'(dc[k]);
        if (rr > 4'd7 || cc > 4'd3) ok = 1'b0;
        else                        m[{rr[2:0], cc[1:0]}] = 1'b1;
      end
    end
    return {ok, m};
  endfunction

  logic [2:0]  state_q, state_d;
  logic [31:0] board_q, base_q, cmask_q, new_board_q;
  logic [1:0]  type_q, rot_q, crot_q, new_rot_q;
  logic [4:0]  loc_q, cloc_q, new_loc_q;
  logic        left_q, right_q, rotreq_q, cok_q, done_q;

  logic [2:0]  cur_row_c;
  logic [2:0]  cur_col_c;
  logic [2:0]  cand_col_c;
  logic [1:0]  cand_rot_c;
  logic        cand_bad_c;
  logic        single_c;
  logic [32:0] cur_place_c;
  logic [32:0] cand_place_c;
  logic        cand_ok_c;

  assign cur_row_c = loc_q[4:2];
  assign cur_col_c = {1'b0, loc_q[1:0]};
  assign single_c  = (2'(left_q) + 2'(right_q) + 2'(rotreq_q)) == 2'd1;
  assign cur_place_c = place_piece(type_q, rot_q, cur_row_c, cur_col_c);

  // Candidate placement for the latched request; right at col 3 yields col 4 and fails bounds.
  always_comb begin
    cand_col_c = cur_col_c;
    cand_rot_c = rot_q;
    cand_bad_c = 1'b0;
    if (single_c) begin
      if (left_q) begin
        if (cur_col_c == 3'd0) cand_bad_c = 1'b1;
        else                   cand_col_c = cur_col_c - 3'd1;
      end else if (right_q) begin
        cand_col_c = cur_col_c + 3'd1;
      end else begin
        cand_rot_c = rot_q + 2'd1;
      end
    end
  end

  assign cand_place_c = place_piece(type_q, cand_rot_c, cur_row_c, cand_col_c);
  assign cand_ok_c    = !cand_bad_c && cand_place_c[32] && ((base_q & cand_place_c[31:0]) == '0);

`ifdef WALL_KICK_EN
  logic [2:0]  kick_col_c;
  logic [32:0] kick_place_c;
  logic        kick_ok_c;
  assign kick_col_c   = cur_col_c - 3'd1;
  assign kick_place_c = place_piece(type_q, rot_q + 2'd1, cur_row_c, kick_col_c);
  assign kick_ok_c    = (cur_col_c != 3'd0) && kick_place_c[32] &&
                        ((base_q & kick_place_c[31:0]) == '0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ERASE;
      S_ERASE:  state_d = S_CHECK;
`ifdef WALL_KICK_EN
      S_CHECK:  state_d = (single_c && rotreq_q && !cand_ok_c) ? S_KICK : S_COMMIT;
      S_KICK:   state_d = S_COMMIT;
`else
      S_CHECK:  state_d = S_COMMIT;
`endif
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: latch request, erase, evaluate candidate, commit result
  always_ff @(posedge clk) begin
    if (reset) begin
      board_q     <= '0;
      base_q      <= '0;
      cmask_q     <= '0;
      type_q      <= '0;
      rot_q       <= '0;
      crot_q      <= '0;
      loc_q       <= '0;
      cloc_q      <= '0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      rotreq_q    <= 1'b0;
      cok_q       <= 1'b0;
      new_loc_q   <= '0;
      new_rot_q   <= '0;
      new_board_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            board_q  <= curr_board_state;
            type_q   <= curr_piece_type;
            loc_q    <= curr_piece_location;
            rot_q    <= curr_piece_rotation;
            left_q   <= left;
            right_q  <= right;
            rotreq_q <= rotate;
          end
        end
        S_ERASE: base_q <= board_q & ~cur_place_c[31:0];
        S_CHECK: begin
          cok_q   <= cand_ok_c;
          cloc_q  <= {cur_row_c, cand_col_c[1:0]};
          crot_q  <= cand_rot_c;
          cmask_q <= cand_place_c[31:0];
        end
`ifdef WALL_KICK_EN
        S_KICK: begin
          cok_q   <= kick_ok_c;
          cloc_q  <= {cur_row_c, kick_col_c[1:0]};
          crot_q  <= rot_q + 2'd1;
          cmask_q <= kick_place_c[31:0];
        end
`endif
        S_COMMIT: begin
          if (cok_q) begin
            new_loc_q   <= cloc_q;
            new_rot_q   <= crot_q;
            new_board_q <= base_q | cmask_q;
          end else begin
            new_loc_q   <= loc_q;
            new_rot_q   <= rot_q;
            new_board_q <= board_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign new_location    = new_loc_q;
  assign new_rotation    = new_rot_q;
  assign new_board_state = new_board_q;
  assign done            = done_q;

endmodule

// File: tb/tb_move_piece_fsm.sv
// Scoreboard bench for move_piece_fsm: the driver pushes expected results, the
// monitor pops and compares on every done pulse (including latency).
module tb_move_piece_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] curr_board_state = '0;
  logic [1:0]  curr_piece_type = '0;
  logic [4:0]  curr_piece_location = '0;
  logic [1:0]  curr_piece_rotation = '0;
  logic        left = 1'b0, right = 1'b0, rotate = 1'b0;
  logic [4:0]  new_location;
  logic [1:0]  new_rotation;
  logic [31:0] new_board_state;
  logic        done;

  move_piece_fsm dut (
    .clk(clk), .reset(reset), .start(start),
    .curr_board_state(curr_board_state), .curr_piece_type(curr_piece_type),
    .curr_piece_location(curr_piece_location), .curr_piece_rotation(curr_piece_rotation),
    .left(left), .right(right), .rotate(rotate),
    .new_location(new_location), .new_rotation(new_rotation),
    .new_board_state(new_board_state), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  loc;
    logic [1:0]  rot;
    logic [31:0] board;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;
  bit   seen_done = 0;
  bit   prev_done = 0;

`ifdef WALL_KICK_EN
  localparam int KICK_LAT = 5;
`else
  localparam int KICK_LAT = 4;
`endif

  always @(posedge clk) cyc++;

  // Monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      if (prev_done) begin
        n_vec++; n_mis++;
        $display("FAIL done_width: done high %0d cycles in a row, required 1", 2);
      end
      if (q.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no request pending", cyc);
      end else begin
        e = q.pop_front();
        n_vec++;
        if (new_location !== e.loc || new_rotation !== e.rot ||
            new_board_state !== e.board || (cyc - e.issue) != e.lat) begin
          n_mis++;
          $display("FAIL %s: got loc=%0d rot=%0d board=%h lat=%0d, required loc=%0d rot=%0d board=%h lat=%0d",
                   e.name, new_location, new_rotation, new_board_state, cyc - e.issue,
                   e.loc, e.rot, e.board, e.lat);
        end
      end
      seen_done = 1;
    end
    prev_done = done;
  end

  task automatic apply(input string name, input logic [1:0] ptype, input logic [4:0] loc,
                       input logic [1:0] rot, input logic [31:0] board,
                       input logic l, input logic r, input logic ro,
                       input logic [4:0] eloc, input logic [1:0] erot,
                       input logic [31:0] eboard, input int lat);
    exp_t e;
    int   waited;
    @(negedge clk);
    seen_done = 0;
    curr_piece_type = ptype; curr_piece_location = loc; curr_piece_rotation = rot;
    curr_board_state = board; left = l; right = r; rotate = ro;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.name = name; e.loc = eloc; e.rot = erot; e.board = eboard; e.lat = lat; e.issue = cyc;
    q.push_back(e);
    // Scramble inputs: the DUT must use only the values latched at start
    curr_board_state = $urandom;
    curr_piece_location = 5'($urandom_range(0, 31));
    curr_piece_rotation = 2'($urandom_range(0, 3));
    curr_piece_type = 2'($urandom_range(0, 3));
    left = ~l; right = ~r; rotate = ~ro;
    waited = 0;
    while (!seen_done && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!seen_done) begin
      n_vec++; n_mis++;
      $display("FAIL %s_timeout: no done within %0d cycles, required done", name, waited);
      if (q.size() != 0) void'(q.pop_front());
    end
    left = 1'b0; right = 1'b0; rotate = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (done !== 1'b0 || new_location !== 5'd0 || new_rotation !== 2'd0 || new_board_state !== 32'd0) begin
      n_mis++;
      $display("FAIL %s: got done=%b loc=%0d rot=%0d board=%h, required all zero",
               name, done, new_location, new_rotation, new_board_state);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;

    apply("noreq",       2'b00, 5'd2,  2'd0, 32'h0000_0004, 0, 0, 0, 5'd2,  2'd0, 32'h0000_0004, 4);
    apply("left",        2'b00, 5'd6,  2'd0, 32'hD000_0040, 1, 0, 0, 5'd5,  2'd0, 32'hD000_0020, 4);
    apply("left_col0",   2'b00, 5'd4,  2'd0, 32'h0000_0010, 1, 0, 0, 5'd4,  2'd0, 32'h0000_0010, 4);
    apply("right_hit",   2'b00, 5'd6,  2'd0, 32'h0000_00C0, 0, 1, 0, 5'd6,  2'd0, 32'h0000_00C0, 4);
    apply("rot_L",       2'b11, 5'd5,  2'd0, 32'h0000_0260, 0, 0, 1, 5'd5,  2'd1, 32'h0000_0460, 4);
`ifdef WALL_KICK_EN
    apply("rot_L_hit",   2'b11, 5'd5,  2'd0, 32'h0000_0660, 0, 0, 1, 5'd4,  2'd1, 32'h0000_0630, 5);
`else
    apply("rot_L_hit",   2'b11, 5'd5,  2'd0, 32'h0000_0660, 0, 0, 1, 5'd5,  2'd0, 32'h0000_0660, 4);
`endif
    apply("right_col3",  2'b00, 5'd3,  2'd0, 32'h0000_0008, 0, 1, 0, 5'd3,  2'd0, 32'h0000_0008, 4);
    apply("multi_req",   2'b00, 5'd6,  2'd0, 32'h0000_0040, 1, 1, 0, 5'd6,  2'd0, 32'h0000_0040, 4);
    apply("rot_domino",  2'b01, 5'd0,  2'd0, 32'h0000_0003, 0, 0, 1, 5'd0,  2'd1, 32'h0000_0011, 4);
    apply("rot_wrap",    2'b01, 5'd0,  2'd3, 32'h0000_0011, 0, 0, 1, 5'd0,  2'd0, 32'h0000_0003, 4);
    apply("rot_I3_floor",2'b10, 5'd24, 2'd0, 32'h0700_0000, 0, 0, 1, 5'd24, 2'd0, 32'h0700_0000, KICK_LAT);
    apply("right_I3",    2'b10, 5'd0,  2'd0, 32'h0000_0007, 0, 1, 0, 5'd1,  2'd0, 32'h0000_000E, 4);
    apply("right_I3_edge",2'b10,5'd1,  2'd0, 32'h8000_000E, 0, 1, 0, 5'd1,  2'd0, 32'h8000_000E, 4);
    apply("left_L_rot2", 2'b11, 5'd1,  2'd2, 32'h0000_0064, 1, 0, 0, 5'd0,  2'd2, 32'h0000_0032, 4);

    // Abort a move with reset mid-operation: outputs clear and no done follows
    @(negedge clk);
    curr_piece_type = 2'b00; curr_piece_location = 5'd6; curr_board_state = 32'h40;
    left = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; left = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_abort");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_zero("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
